// File: rtl/i2c_sensor_target.sv
// I2C target returning a 16-bit sensor snapshot on reads and emitting written bytes on rx_data/rx_valid.
// Bus events act 3 clk after the pin changes; the bus master paces everything, so there is no backpressure and rx_valid is a one-clk pulse.
module i2c_sensor_target #(
    parameter logic [6:0] ADDR      = 7'b1001000,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] sensor_data,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rd_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_TX_BYTE,
        S_TX_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_pipe_q, scl_pipe_d;
    logic [2:0]  sda_pipe_q, sda_pipe_d;
    logic [6:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        rw_q, rw_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] snap_q, snap_d;
    logic        ack_phase_q, ack_phase_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rd_done_q, rd_done_d;

    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall, start_evt, stop_evt;
    logic        addr_hit;
    logic [7:0]  tx_byte;

    // Pipe bit 1 is the synchronized level, bit 2 the one-clk-older copy for edge detection.
    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_in};
        sda_pipe_d = {sda_pipe_q[1:0], sda_in};
    end

    assign scl_s     = scl_pipe_q[1];
    assign sda_s     = sda_pipe_q[1];
    assign scl_rise  = scl_s & ~scl_pipe_q[2];
    assign scl_fall  = ~scl_s & scl_pipe_q[2];
    assign start_evt = scl_s & scl_pipe_q[2] & ~sda_s & sda_pipe_q[2];
    assign stop_evt  = scl_s & scl_pipe_q[2] & sda_s & ~sda_pipe_q[2];
    assign addr_hit  = (shift_q == ADDR) && (shift_q != 7'd0);

    always_comb begin
        tx_byte = FILL_BYTE;
        case (byte_idx_q)
            2'd0:    tx_byte = snap_q[15:8];
            2'd1:    tx_byte = snap_q[7:0];
            default: tx_byte = FILL_BYTE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rw_d        = rw_q;
        byte_idx_d  = byte_idx_q;
        snap_d      = snap_q;
        ack_phase_d = ack_phase_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rd_done_d   = 1'b0;

        if (start_evt) begin
            state_d   = S_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
        end else if (stop_evt) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            // shift_q still holds the 7 address bits; sda_s is R/W.
                            if (addr_hit) begin
                                state_d     = S_ADDR_ACK;
                                busy_d      = 1'b1;
                                snap_d      = sensor_data;
                                rw_d        = sda_s;
                                byte_idx_d  = 2'd0;
                                ack_phase_d = 1'b0;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_RX_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else if (state_q == S_ADDR_ACK && rw_q) begin
                            state_d   = S_TX_BYTE;
                            sda_oe_d  = ~tx_byte[7];
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d   = S_RX_BYTE;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                S_TX_BYTE: begin
                    // bit_cnt counts bits already placed on the bus.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_TX_ACK;
                        end else begin
                            sda_oe_d  = ~tx_byte[3'd7 - bit_cnt_q[2:0]];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            if (byte_idx_q != 2'd2) begin
                                byte_idx_d = byte_idx_q + 2'd1;
                            end
                            state_d   = S_TX_BYTE;
                            bit_cnt_d = 4'd0;
                        end else begin
                            rd_done_d = 1'b1;
                            state_d   = S_WAIT_STOP;
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d   = {shift_q, sda_s};
                            rx_valid_d  = 1'b1;
                            state_d     = S_RX_ACK;
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizers reset to the idle-high bus level so release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            scl_pipe_q  <= 3'b111;
            sda_pipe_q  <= 3'b111;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rw_q        <= 1'b0;
            byte_idx_q  <= '0;
            snap_q      <= '0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_pipe_q  <= scl_pipe_d;
            sda_pipe_q  <= sda_pipe_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rw_q        <= rw_d;
            byte_idx_q  <= byte_idx_d;
            snap_q      <= snap_d;
            ack_phase_q <= ack_phase_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rd_done  = rd_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bench for i2c_sensor_target: a bit-banged master drives directed frames; expected bytes, ACKs and pulses
// are queued at issue time and a separate monitor pops and compares them as the DUT presents them.
module tb_i2c_sensor_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        sda_bus;
    logic [15:0] sensor_data;
    logic        sda_oe;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rd_done;
    logic        busy;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_sensor_target #(.ADDR(7'b1001000), .FILL_BYTE(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .sensor_data(sensor_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rd_done    (rd_done),
        .busy       (busy)
    );

    typedef struct packed {
        logic       is_byte;
        logic [7:0] val;
    } bus_item_t;

    int          total = 0;
    int          bad   = 0;
    bus_item_t   exp_bus[$];
    bus_item_t   obs_bus[$];
    logic [7:0]  exp_rx[$];
    int          exp_rd[$];
    logic        watch_oe = 1'b0;
    int          oe_viol  = 0;

    function automatic bus_item_t mk(input logic is_b, input logic [7:0] v);
        bus_item_t t;
        t.is_byte = is_b;
        t.val     = v;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: compares every DUT-presented output against the queued expectation.
    always @(negedge clk) begin : mon
        bus_item_t  o, e;
        logic [7:0] er;
        int         dummy;
        if (rx_valid) begin
            total++;
            if (exp_rx.size() == 0) begin
                bad++;
                $display("FAIL rx_valid_unexpected: rx_data=%h want no pulse", rx_data);
            end else begin
                er = exp_rx.pop_front();
                if (rx_data !== er) begin
                    bad++;
                    $display("FAIL rx_data: got %h want %h", rx_data, er);
                end
            end
        end
        if (rd_done) begin
            total++;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL rd_done_unexpected: got pulse want none");
            end else begin
                dummy = exp_rd.pop_front();
            end
        end
        while (obs_bus.size() > 0) begin
            o = obs_bus.pop_front();
            total++;
            if (exp_bus.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected: got kind=%0d val=%h", o.is_byte, o.val);
            end else begin
                e = exp_bus.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL bus_%s: got %h want %h", e.is_byte ? "byte" : "ack", o.val, e.val);
                end
            end
        end
        if (watch_oe && sda_oe) oe_viol++;
    end

    // SCL quarter period is 5 clk, so one SCL period is 20 clk.
    task automatic qd();
        repeat (5) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; qd();
        scl_m = 1'b1; qd();
        sda_m = 1'b0; qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; qd();
        scl_m = 1'b1; qd();
        sda_m = 1'b1; qd();
    endtask

    task automatic m_wbit(input logic b);
        sda_m = b;    qd();
        scl_m = 1'b1; qd(); qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic m_rbit(output logic b);
        sda_m = 1'b1; qd();
        scl_m = 1'b1; qd();
        b = sda_bus;  qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic m_wbyte(input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_bus.push_back(mk(1'b0, {7'd0, exp_ack}));
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
        m_rbit(a);
        obs_bus.push_back(mk(1'b0, {7'd0, a}));
    endtask

    task automatic m_rbyte(input logic [7:0] exp_val, input logic master_ack);
        logic       b;
        logic [7:0] d;
        exp_bus.push_back(mk(1'b1, exp_val));
        for (int i = 7; i >= 0; i--) begin
            m_rbit(b);
            d[i] = b;
        end
        obs_bus.push_back(mk(1'b1, d));
        m_wbit(~master_ack);
    endtask

    task automatic frame_end(input string name);
        repeat (10) @(negedge clk);
        check({name, "_rx_pending"}, exp_rx.size(), 0);
        check({name, "_rd_pending"}, exp_rd.size(), 0);
        check({name, "_bus_pending"}, exp_bus.size(), 0);
        check({name, "_busy_after_stop"}, busy, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; sensor_data = 16'h1A80;
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Read frame: 0x91, ACK 0x1A, NACK 0x80.
        m_start();
        m_wbyte(8'h91, 1'b0);
        check("read_busy_after_addr", busy, 1);
        exp_rd.push_back(1);
        m_rbyte(8'h1A, 1'b1);
        m_rbyte(8'h80, 1'b0);
        m_stop();
        frame_end("read");

        // Address miss: target must stay completely passive.
        oe_viol = 0;
        watch_oe = 1'b1;
        m_start();
        m_wbyte(8'h93, 1'b1);
        check("miss_busy", busy, 0);
        m_rbyte(8'hFF, 1'b0);
        m_stop();
        watch_oe = 1'b0;
        check("miss_oe_never_driven", oe_viol, 0);
        frame_end("miss");

        // Write frame.
        m_start();
        m_wbyte(8'h90, 1'b0);
        exp_rx.push_back(8'h01);
        m_wbyte(8'h01, 1'b0);
        exp_rx.push_back(8'h60);
        m_wbyte(8'h60, 1'b0);
        m_stop();
        frame_end("write");

        // Overread: fill bytes past the second.
        sensor_data = 16'h5AC3;
        m_start();
        m_wbyte(8'h91, 1'b0);
        exp_rd.push_back(1);
        m_rbyte(8'h5A, 1'b1);
        m_rbyte(8'hC3, 1'b1);
        m_rbyte(8'hFF, 1'b1);
        m_rbyte(8'hFF, 1'b0);
        m_stop();
        frame_end("overread");

        // Snapshot held across a sensor change, refreshed by repeated START.
        sensor_data = 16'h0100;
        m_start();
        m_wbyte(8'h91, 1'b0);
        sensor_data = 16'h0200;
        exp_rd.push_back(1);
        m_rbyte(8'h01, 1'b1);
        m_rbyte(8'h00, 1'b0);
        m_start();
        m_wbyte(8'h91, 1'b0);
        exp_rd.push_back(2);
        m_rbyte(8'h02, 1'b1);
        m_rbyte(8'h00, 1'b0);
        m_stop();
        frame_end("snapshot");

        // Reset while the address ACK is being driven.
        sensor_data = 16'h1234;
        m_start();
        for (int i = 7; i >= 0; i--) m_wbit(i == 0 ? 1'b0 : ((8'h90 >> i) & 8'h01) != 8'h00);
        sda_m = 1'b1;
        for (int i = 0; i < 50 && !sda_oe; i++) @(negedge clk);
        check("rst_mid_ack_driven", sda_oe, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ack_oe_released", sda_oe, 0);
        check("rst_mid_ack_busy", busy, 0);
        repeat (3) @(negedge clk);
        scl_m = 1'b1;
        sda_m = 1'b1;
        qd();
        rst = 1'b1;
        qd();
        m_start();
        m_wbyte(8'h91, 1'b0);
        exp_rd.push_back(1);
        m_rbyte(8'h12, 1'b1);
        m_rbyte(8'h34, 1'b0);
        m_stop();
        frame_end("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_sensor_target.md
Name: i2c_sensor_target

Overview:
- I2C target (slave) responder that answers the sensor-polling master, modelling one temperature or lux sensor on the shared SCL/SDA bus.
- Oversamples SCL/SDA with the system clock, detects START/STOP, matches its 7-bit address and ACKs the address byte.
- On a read, returns a 16-bit snapshot of sensor data, MSB first.
- On a write, accepts data bytes, ACKs each one and presents them on a byte-valid output.
- Used in bench models and in any sensor emulation on the board.

Parameters:
- ADDR, 7'b1001000, target 7-bit address; instances are built for 1001000..1001011 (temperature) and 1000100..1000111 (lux).
- FILL_BYTE, 8'hFF, byte returned for read bytes beyond the second.

Ports:
- clk  input  1  system clock; frequency must be at least 10x SCL.
- rst  input  1  asynchronous, active-low reset.
- scl_in  input  1  raw bus SCL level.
- sda_in  input  1  raw bus SDA level.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release SDA.
- sensor_data  input  16  value to return on a read; sampled at address match.
- rx_data  output  8  last byte received in a write.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- rd_done  output  1  one-clk pulse when the master NACKs a read byte.
- busy  output  1  high from an address match until the next STOP or START.

Behaviour:
- Reset (rst=0, async): state IDLE; sda_oe=0, rx_data=0, rx_valid=0, rd_done=0, busy=0; shift register, bit counter and byte index cleared.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer, then a 1-flop delay for edge detection.
  - All bus events are seen 3 clk after the pin changes.
- Event detection:
  - START = synchronized SDA falls while SCL is high.
  - STOP = synchronized SDA rises while SCL is high.
  - SDA changes while SCL is low are data and are never decoded as events.
- States: IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, WAIT_STOP.
- Sampling rules:
  - Data bits are sampled on the synchronized SCL rising edge.
  - sda_oe changes only on the synchronized SCL falling edge, except for the release on START/STOP.
- START from any state: go to ADDR, sda_oe=0, bit counter=0, busy=0. This covers repeated start.
- STOP from any state: go to IDLE, sda_oe=0, busy=0.
- ADDR:
  - Shift 8 bits MSB first (7 address bits, then R/W).
  - After the 8th rising edge: if bits[7:1]==ADDR, go to ADDR_ACK, set busy=1, and latch sensor_data into the tx snapshot in that same clk.
  - Otherwise go to WAIT_STOP (stay passive until the next START or STOP).
- ADDR_ACK:
  - On the next falling edge, sda_oe=1.
  - On the following falling edge, sda_oe is released.
  - Then enter TX_BYTE if R/W=1, or RX_BYTE if R/W=0.
- TX_BYTE:
  - Byte 0 = snapshot[15:8], byte 1 = snapshot[7:0], bytes 2 and later = FILL_BYTE.
  - The first bit is driven on the same falling edge that ends the ACK: sda_oe = ~bit.
  - Each later bit is driven on the next falling edge.
  - After 8 bits, release SDA on the falling edge and go to TX_ACK.
- TX_ACK:
  - Sample SDA on the rising edge.
  - 0 (ACK): increment byte index (saturating at 2) and go to TX_BYTE.
  - 1 (NACK): pulse rd_done and go to WAIT_STOP.
- RX_BYTE:
  - Shift 8 bits.
  - On the 8th rising edge: rx_data <= shifted byte, pulse rx_valid, go to RX_ACK.
- RX_ACK: drive ACK over one SCL period exactly as in ADDR_ACK, then return to RX_BYTE. There is no byte limit.
- Snapshot: the read data is the value at address match. Changes to sensor_data during the read are not seen until the next transaction.
- Reset mid-transfer releases SDA immediately. The target stays in IDLE until a fresh START, so a partial frame is ignored.
- General-call address 0000000 is not acknowledged.

Test Plan:
- Read frame: ADDR=7'b1001000, sensor_data=16'h1A80, master sends START, 0x91, ACK, NACK, STOP.
  - Target ACKs the address and shifts out 0x1A then 0x80.
  - rd_done pulses once; busy ends at STOP.
- Address miss: same instance, master sends 0x93 (address 1001001).
  - sda_oe stays 0 for the whole frame; no pulses on rx_valid or rd_done.
- Write frame: START, 0x90, 0x01, 0x60, STOP.
  - ACKs on all three bytes.
  - rx_valid pulses twice, rx_data=0x01 then 0x60.
- Overread: master ACKs three read bytes, then NACKs.
  - Bytes returned are MSB, LSB, 0xFF, 0xFF; rd_done pulses after the fourth byte.
- Snapshot and repeated start:
  - sensor_data changes from 16'h0100 to 16'h0200 mid-read; the bytes returned are still 0x01, 0x00.
  - A repeated START followed by 0x91 then returns 0x02, 0x00.
- Reset mid-ACK: assert rst while sda_oe=1.
  - sda_oe=0 within the same clk.
  - After release, the next full read frame completes correctly.
